// File: rtl/ahb_mst_arb_pkg.sv
// rtl/ahb_mst_arb_pkg.sv - shared types and AHB encodings for the AHB master arbiter
//   Contents: FSM state enum, HTRANS/HBURST/HRESP constants.
package ahb_mst_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

endpackage

// File: rtl/ahb_mst_arb_rr.sv
// rtl/ahb_mst_arb_rr.sv - combinational round-robin picker (module rr_arb)
//   eligible : per-requester candidates
//   ptr      : index of the last winner; search starts at ptr+1 and wraps
//   upd      : arbitration strobe; all outputs are zero while low
//   grant    : one-hot winner
//   idx      : encoded winner
//   any      : a winner exists this cycle
module rr_arb #(
  parameter int rq_c = 2
) (
  input  logic [rq_c-1:0]         eligible,
  input  logic [$clog2(rq_c)-1:0] ptr,
  input  logic                    upd,
  output logic [rq_c-1:0]         grant,
  output logic [$clog2(rq_c)-1:0] idx,
  output logic                    any
);

  localparam int id_w = $clog2(rq_c);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    if (upd) begin
      // Offsets 1..rq_c visit every requester once, ending on the last winner itself.
      for (int k = 1; k <= rq_c; k++) begin
        if (!any && eligible[(int'(ptr) + k) % rq_c]) begin
          any = 1'b1;
          idx = id_w'((int'(ptr) + k) % rq_c);
          grant[(int'(ptr) + k) % rq_c] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_mst_arb.sv
// rtl/ahb_mst_arb.sv - round-robin sharing of one AHB-Lite master port between rq_c requesters
//   Optional data-phase timeout: define AHB_MST_ARB_TIMEOUT_EN.
//   hclk, hreset                  : clock, synchronous active-high reset
//   req, req_addr, req_wdata,
//   req_we, req_size              : per-requester level request and transfer fields
//   ack, rsp_rdata, rsp_err       : one-cycle completion pulse with read data / error
//   gnt_id                        : current or last granted requester
//   haddr, hwdata, hwrite, htrans,
//   hsize, hburst                 : AHB master outputs
//   hrdata, hresp, hready         : AHB master inputs
module ahb_mst_arb
  import ahb_mst_arb_pkg::*;
#(
  parameter int rq_c   = 2,
  parameter int to_w   = 8,
  parameter int to_lim = 200
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [rq_c-1:0]              req,
  input  logic [rq_c-1:0][31:0]        req_addr,
  input  logic [rq_c-1:0][31:0]        req_wdata,
  input  logic [rq_c-1:0]              req_we,
  input  logic [rq_c-1:0][2:0]         req_size,
  output logic [rq_c-1:0]              ack,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic [$clog2(rq_c)-1:0]      gnt_id,
  output logic [31:0]                  haddr,
  output logic [31:0]                  hwdata,
  input  logic [31:0]                  hrdata,
  output logic                         hwrite,
  output logic [1:0]                   htrans,
  output logic [2:0]                   hsize,
  output logic [2:0]                   hburst,
  input  logic [1:0]                   hresp,
  input  logic                         hready
);

  localparam int id_w = $clog2(rq_c);

  state_t            state, state_nx;
  logic [id_w-1:0]   ptr;
  logic [rq_c-1:0]   eligible;
  logic [rq_c-1:0]   pick_oh;
  logic [id_w-1:0]   pick_idx;
  logic              pick_any;
  logic [rq_c-1:0]   gnt_oh;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic              tmo;

  // A requester pulsing ack still shows its old req this cycle; keep it out.
  assign eligible = req & ~ack;

  rr_arb #(.rq_c(rq_c)) u_rr (
    .eligible (eligible),
    .ptr      (ptr),
    .upd      (state == ST_IDLE),
    .grant    (pick_oh),
    .idx      (pick_idx),
    .any      (pick_any)
  );

`ifdef AHB_MST_ARB_TIMEOUT_EN
  logic [to_w-1:0] wcnt;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wcnt <= '0;
    end else if (state == ST_ADDR && hready) begin
      wcnt <= '0;
    end else if (state == ST_DATA && !hready) begin
      wcnt <= wcnt + to_w'(1);
    end
  end

  // Fires on the wait state that brings the count to to_lim, so ack lands
  // exactly to_lim cycles after the first data-phase cycle.
  assign tmo = (state == ST_DATA) && !hready && (wcnt == to_w'(to_lim - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_any) state_nx = ST_ADDR;
      ST_ADDR: if (hready) state_nx = ST_DATA;
      ST_DATA: if (hready || tmo) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      ptr       <= id_w'(rq_c - 1);
      gnt_id    <= '0;
      gnt_oh    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (state == ST_IDLE && pick_any) begin
        ptr     <= pick_idx;
        gnt_id  <= pick_idx;
        gnt_oh  <= pick_oh;
        addr_q  <= req_addr[pick_idx];
        wdata_q <= req_wdata[pick_idx];
        we_q    <= req_we[pick_idx];
        size_q  <= req_size[pick_idx];
      end
      if (state == ST_DATA && hready) begin
        ack       <= gnt_oh;
        rsp_rdata <= we_q ? 32'h0 : hrdata;
        rsp_err   <= (hresp == HRESP_ERROR);
      end else if (tmo) begin
        ack     <= gnt_oh;
        rsp_err <= 1'b1;
      end
    end
  end

  // Bus outputs are decoded from the state and the latched transfer, so a
  // reset drops htrans to IDLE on the very next edge.
  assign htrans = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite = (state == ST_ADDR) && we_q;
  assign haddr  = addr_q;
  assign hsize  = size_q;
  assign hwdata = wdata_q;
  assign hburst = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb_mst_arb.sv
// tb/tb_ahb_mst_arb.sv - self-checking bench for ahb_mst_arb
module tb_ahb_mst_arb;

  localparam int N = 3;

  logic                  clk;
  logic                  hreset;
  logic [N-1:0]          req;
  logic [N-1:0][31:0]    req_addr;
  logic [N-1:0][31:0]    req_wdata;
  logic [N-1:0]          req_we;
  logic [N-1:0][2:0]     req_size;
  logic [N-1:0]          ack;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [$clog2(N)-1:0]  gnt_id;
  logic [31:0]           haddr;
  logic [31:0]           hwdata;
  logic [31:0]           hrdata;
  logic                  hwrite;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [1:0]            hresp;
  logic                  hready;

  int tests = 0;
  int fails = 0;

  ahb_mst_arb #(.rq_c(N), .to_w(8), .to_lim(200)) dut (
    .hclk(clk), .hreset(hreset), .req(req), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
    .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .gnt_id(gnt_id),
    .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hburst(hburst), .hresp(hresp),
    .hready(hready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_xfer(input int r);
    req_addr[r]  = $urandom & 32'hFFFF_FFFC;
    req_wdata[r] = $urandom;
    req_we[r]    = 1'($urandom_range(0, 1));
    req_size[r]  = 3'($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    req    = '0;
    hready = 1'b1;
    hresp  = 2'b00;
    @(negedge clk);
    @(negedge clk);
    hreset = 1'b0;
  endtask

  // Round-robin rule: first candidate after the previous winner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] e, input int last);
    for (int k = 1; k <= N; k++) begin
      if (e[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  logic [N-1:0] got;
  logic [N-1:0] arb_req, arb_ack, exp_ack;
  logic [31:0]  exp_rdata;
  logic         exp_err, err2, done, early;
  int           ph, win, last_win, sel;
  int           idle_cnt [N];

  initial begin
    hreset = 1'b1; req = '0; req_addr = '0; req_wdata = '0; req_we = '0;
    req_size = '0; hrdata = '0; hresp = 2'b00; hready = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_htrans", htrans, 0);
    chk("rst_ack", ack, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hsize", hsize, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_hburst", hburst, 0);
    hreset = 1'b0;

    // single write, zero wait states
    req_addr[0] = 32'h4; req_wdata[0] = 32'hA5; req_we[0] = 1'b1; req_size[0] = 3'd2;
    req[0] = 1'b1;
    @(negedge clk);
    chk("t1_htrans", htrans, 2'b10);
    chk("t1_haddr", haddr, 32'h4);
    chk("t1_hwrite", hwrite, 1);
    chk("t1_hsize", hsize, 2);
    chk("t1_gnt", gnt_id, 0);
    chk("t1_ack_c1", ack, 0);
    @(negedge clk);
    chk("t1_dtrans", htrans, 0);
    chk("t1_hwdata", hwdata, 32'hA5);
    chk("t1_dwrite", hwrite, 0);
    chk("t1_ack_c2", ack, 0);
    @(negedge clk);
    chk("t1_ack", ack, 3'b001);
    chk("t1_err", rsp_err, 0);
    chk("t1_rdata", rsp_rdata, 0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_clr", ack, 0);

    // read with 3 data wait states
    req_addr[0] = 32'h0001_0000; req_we[0] = 1'b0; req_size[0] = 3'd2; req[0] = 1'b1;
    @(negedge clk);
    chk("t2_htrans", htrans, 2'b10);
    chk("t2_haddr", haddr, 32'h0001_0000);
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t2_ack_c5", ack, 0);
    hready = 1'b1; hrdata = 32'h1234_5678;
    @(negedge clk);
    chk("t2_ack", ack, 3'b001);
    chk("t2_rdata", rsp_rdata, 32'h1234_5678);
    chk("t2_err", rsp_err, 0);
    req[0] = 1'b0; hrdata = '0;

    // back-to-back alternation
    do_reset();
    hrdata = 32'hCAFE_F00D;
    new_xfer(0); new_xfer(1);
    req[0] = 1'b1; req[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = '0;
      for (int c = 0; c < 20 && got == '0; c++) begin
        @(negedge clk);
        got = ack;
      end
      if (got == '0) chk("b2b_wait", 32'(|ack), 1);
      chk("b2b_ack", got, (k % 2 == 0) ? 3'b001 : 3'b010);
      chk("b2b_gnt", gnt_id, k % 2);
      chk("b2b_rdata", rsp_rdata, req_we[k % 2] ? 32'h0 : 32'hCAFE_F00D);
      if (k < 4) new_xfer(k % 2);
      else req[k % 2] = 1'b0;
    end
    @(negedge clk);

    // two-cycle ERROR response
    req_addr[0] = 32'h20; req_we[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    chk("t4_htrans", htrans, 2'b10);
    @(negedge clk);
    hready = 1'b0; hresp = 2'b01;
    @(negedge clk);
    chk("t4_ack_first", ack, 0);
    hready = 1'b1; hresp = 2'b01; hrdata = 32'h55;
    @(negedge clk);
    chk("t4_ack", ack, 3'b001);
    chk("t4_err", rsp_err, 1);
    chk("t4_rdata", rsp_rdata, 32'h55);
    hresp = 2'b00; req[0] = 1'b0;
    @(negedge clk);
    chk("t4_ack_clr", ack, 0);
    chk("t4_err_clr", rsp_err, 0);

    // reset during a data wait state
    new_xfer(0); req[0] = 1'b1;
    @(negedge clk);
    chk("t5_htrans", htrans, 2'b10);
    @(negedge clk);
    hready = 1'b0; new_xfer(1); req[1] = 1'b1;
    @(negedge clk);
    hreset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    chk("t5_rst_htrans", htrans, 0);
    chk("t5_rst_ack", ack, 0);
    hreset = 1'b0; hready = 1'b1;
    @(negedge clk);
    chk("t5_htrans1", htrans, 2'b10);
    chk("t5_gnt1", gnt_id, 1);
    chk("t5_haddr1", haddr, req_addr[1]);
    new_xfer(0); req[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      got = '0;
      for (int c = 0; c < 10 && got == '0; c++) begin
        @(negedge clk);
        got = ack;
      end
      chk("t5_order", got, (k == 0) ? 3'b010 : 3'b001);
      req[(k == 0) ? 1 : 0] = 1'b0;
    end

    // stuck hready in the data phase
    do_reset();
    req_addr[0] = 32'h40; req_we[0] = 1'b0; req[0] = 1'b1;
    @(negedge clk);
    chk("t6_htrans", htrans, 2'b10);
    @(negedge clk);
    hready = 1'b0;
    early = 1'b0;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (ack != '0) early = 1'b1;
    end
    chk("t6_no_early_ack", early, 0);
    @(negedge clk);
`ifdef AHB_MST_ARB_TIMEOUT_EN
    chk("t6_tmo_ack", ack, 3'b001);
    chk("t6_tmo_err", rsp_err, 1);
    chk("t6_tmo_rdata", rsp_rdata, 0);
    req[0] = 1'b0;
    @(negedge clk);
    chk("t6_tmo_htrans", htrans, 0);
    chk("t6_tmo_ack_clr", ack, 0);
    hready = 1'b1;
`else
    if (ack != '0) early = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (ack != '0) early = 1'b1;
    end
    chk("t6_no_tmo_ack", early, 0);
    chk("t6_no_tmo_htrans", htrans, 0);
`endif

    // randomized traffic against the round-robin/response model
    do_reset();
    ph = 0; err2 = 1'b0; last_win = N - 1;
    arb_req = '0; arb_ack = '0; exp_ack = '0; exp_rdata = '0; exp_err = 1'b0;
    for (int r = 0; r < N; r++) idle_cnt[r] = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (exp_ack != '0) begin
        chk("rnd_ack", ack, exp_ack);
        chk("rnd_rdata", rsp_rdata, exp_rdata);
        chk("rnd_err", rsp_err, exp_err);
        exp_ack = '0;
      end else begin
        chk("rnd_ack_idle", ack, 0);
      end
      if (ph == 0 && htrans == 2'b10) begin
        win = rr_pick(arb_req & ~arb_ack, last_win);
        chk("rnd_gnt", gnt_id, win);
        if (win >= 0) begin
          chk("rnd_haddr", haddr, req_addr[win]);
          chk("rnd_hwrite", hwrite, req_we[win]);
          chk("rnd_hsize", hsize, req_size[win]);
          last_win = win;
        end
        ph = 1;
      end
      hready = 1'b1; hresp = 2'b00; done = 1'b0;
      if (ph == 1) begin
        hready = 1'($urandom_range(0, 3) != 0);
        if (hready) ph = 2;
      end else if (ph == 2) begin
        if (req_we[last_win]) chk("rnd_hwdata", hwdata, req_wdata[last_win]);
        if (err2) begin
          hresp = 2'b01; done = 1'b1; exp_err = 1'b1;
        end else begin
          sel = $urandom_range(0, 9);
          if (sel < 2) begin
            hready = 1'b0; hresp = 2'b01; err2 = 1'b1;
          end else if (sel < 5) begin
            hready = 1'b0;
          end else begin
            done = 1'b1; exp_err = 1'b0;
          end
        end
        if (done) begin
          hrdata    = $urandom;
          exp_ack   = N'(1) << last_win;
          exp_rdata = req_we[last_win] ? 32'h0 : hrdata;
          ph = 0; err2 = 1'b0;
        end
      end
      for (int r = 0; r < N; r++) begin
        if (ack[r]) begin
          if ($urandom_range(0, 1) == 1) new_xfer(r);
          else begin
            req[r] = 1'b0;
            idle_cnt[r] = $urandom_range(0, 3);
          end
        end else if (!req[r]) begin
          if (idle_cnt[r] == 0) begin
            new_xfer(r);
            req[r] = 1'b1;
          end else begin
            idle_cnt[r]--;
          end
        end
      end
      arb_req = req;
      arb_ack = ack;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
